rf_writeback_arbiter: RTL and testbench

- Write-side front end of the integer register file.
- Collects results from two producers, the EXU (ALU, single-cycle) and the LSU (loads, buffered), and serializes them onto the single RF write port (wen/waddr/wdata) at one write per cycle.
- Maintains a per-register pending-write scoreboard so decode can detect RAW hazards before reading the RF.

---
 rtl/rf_writeback_arbiter.sv | 152 +++++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// Write-side front end of the integer register file: merges EXU and buffered LSU
// results onto one RF write port and tracks pending writes for RAW/WAW detection.
module rf_writeback_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LSU_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rd_busy
);

    localparam int NREG  = 1 << ADDR_WIDTH;
    localparam int PTR_W = $clog2(LSU_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // LSU result FIFO; the head is read combinationally so it can compete this cycle
    logic [ADDR_WIDTH-1:0] fifo_rd_mem   [LSU_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_mem [LSU_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    logic                  lsu_prio_reg;
    logic                  conflict;
    logic                  grant_exu;
    logic                  grant_lsu;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0] grant_data;

    logic                  rf_wen_reg;
    logic [ADDR_WIDTH-1:0] rf_waddr_reg;
    logic [DATA_WIDTH-1:0] rf_wdata_reg;
    logic [NREG-1:0]       busy_reg;

    assign fifo_full  = (count_reg == CNT_W'(LSU_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign lsu_ready  = !fifo_full;
    assign push       = lsu_valid && !fifo_full;
    assign pop        = grant_lsu;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_reg]   <= lsu_rd;
            fifo_data_mem[wr_ptr_reg] <= lsu_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    // Round-robin: on a conflict the side flagged by lsu_prio_reg wins, and the
    // flag then points at whichever side lost.
    assign conflict   = exu_valid && !fifo_empty;
    assign grant_exu  = exu_valid && (fifo_empty || !lsu_prio_reg);
    assign grant_lsu  = !fifo_empty && (!exu_valid || lsu_prio_reg);
    assign grant      = grant_exu || grant_lsu;
    assign grant_rd   = grant_exu ? exu_rd   : fifo_rd_mem[rd_ptr_reg];
    assign grant_data = grant_exu ? exu_data : fifo_data_mem[rd_ptr_reg];
    assign exu_ready  = grant_exu;

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_prio_reg <= 1'b0;
        end else if (conflict) begin
            lsu_prio_reg <= grant_exu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_reg   <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
        end else if (grant) begin
            rf_wen_reg   <= (grant_rd != '0);
            rf_waddr_reg <= grant_rd;
            rf_wdata_reg <= grant_data;
        end else begin
            rf_wen_reg <= 1'b0;
        end
    end

    assign rf_wen   = rf_wen_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;

    // Scoreboard bit per register; a new issue beats a same-edge completion.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            assign set_hit = (gi != 0) && issue_valid && (issue_rd == ADDR_WIDTH'(gi));
            assign clr_hit = grant && (grant_rd == ADDR_WIDTH'(gi));
            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_reg[gi] <= 1'b0;
                end else if (set_hit) begin
                    busy_reg[gi] <= 1'b1;
                end else if (clr_hit) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign rs1_busy = busy_reg[rs1] || (rf_wen_reg && (rf_waddr_reg == rs1) && (rs1 != '0));
    assign rs2_busy = busy_reg[rs2] || (rf_wen_reg && (rf_waddr_reg == rs2) && (rs2 != '0));
    assign rd_busy  = busy_reg[issue_rd];

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Bench for rf_writeback_arbiter: directed scenarios plus random traffic, all
// checked against a queue/array reference model of the write-back rules.
module tb_rf_writeback_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic          exu_valid = 1'b0;
    logic          exu_ready;
    logic [AW-1:0] exu_rd = '0;
    logic [DW-1:0] exu_data = '0;
    logic          lsu_valid = 1'b0;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd = '0;
    logic [DW-1:0] lsu_data = '0;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rs1 = '0;
    logic [AW-1:0] rs2 = '0;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          rd_busy;

    rf_writeback_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LSU_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    // Reference model state
    ent_t          lsu_q[$];
    bit            sb[32];
    bit            lsu_turn;
    logic          m_wen;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_exu_acc;
    bit            m_lsu_acc;
    bit            comb_check = 1'b0;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        lsu_q.delete();
        for (int i = 0; i < 32; i++) sb[i] = 1'b0;
        lsu_turn = 1'b0;
        m_wen    = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    // One clock: check combinational outputs mid-cycle, step the model, then
    // check the registered write port just after the edge.
    task automatic cycle();
        bit   head;
        bit   room;
        bit   exu_win;
        ent_t g;
        @(negedge clk);
        head    = lsu_q.size() > 0;
        room    = lsu_q.size() < DEPTH;
        exu_win = exu_valid && (!head || !lsu_turn);
        if (comb_check) begin
            chk("exu_ready", 32'(exu_ready), 32'(exu_win));
            chk("lsu_ready", 32'(lsu_ready), 32'(room));
            chk("rs1_busy", 32'(rs1_busy),
                32'(sb[rs1] || (m_wen && m_waddr == rs1 && rs1 != 0)));
            chk("rs2_busy", 32'(rs2_busy),
                32'(sb[rs2] || (m_wen && m_waddr == rs2 && rs2 != 0)));
            chk("rd_busy", 32'(rd_busy), 32'(sb[issue_rd]));
        end
        m_exu_acc = !rst && exu_win;
        m_lsu_acc = !rst && lsu_valid && room;
        if (rst) begin
            model_reset();
        end else begin
            if (exu_valid && head) lsu_turn = exu_win;
            if (exu_win || head) begin
                if (exu_win) begin
                    g.rd   = exu_rd;
                    g.data = exu_data;
                end else begin
                    g = lsu_q.pop_front();
                end
                m_wen   = (g.rd != 0);
                m_waddr = g.rd;
                m_wdata = g.data;
                sb[g.rd] = 1'b0;
            end else begin
                m_wen = 1'b0;
            end
            if (issue_valid && issue_rd != 0) sb[issue_rd] = 1'b1;
            if (lsu_valid && room) begin
                g.rd   = lsu_rd;
                g.data = lsu_data;
                lsu_q.push_back(g);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("rf_wen", 32'(rf_wen), 32'(m_wen));
        chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        chk("rf_wdata", rf_wdata, m_wdata);
        comb_check = 1'b1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        exu_valid   = 1'b0;
        lsu_valid   = 1'b0;
    endtask

    initial begin
        int e;
        int l;
        int n;
        model_reset();
        // Reset, then idle
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("idle_exu_ready", 32'(exu_ready), 32'd0);
        chk("idle_lsu_ready", 32'(lsu_ready), 32'd1);

        // Issue x5, EXU completes two cycles later; watch rs1=5
        rs1 = 5'd5;
        issue_valid = 1'b1; issue_rd = 5'd5;
        cycle();
        idle();
        cycle();
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEAD_BEEF;
        cycle();
        idle();
        cycle();
        chk("wb5_busy_gone", 32'(rs1_busy), 32'd0);
        cycle();

        // Both producers streaming: EXU rd 1..8, LSU rd 9..16
        e = 0; l = 0;
        for (int c = 0; c < 60 && (e < 8 || l < 8); c++) begin
            exu_valid = (e < 8); exu_rd = AW'(e + 1); exu_data = 32'hE000_0000 + 32'(e);
            lsu_valid = (l < 8); lsu_rd = AW'(l + 9); lsu_data = 32'hA000_0000 + 32'(l);
            cycle();
            if (m_exu_acc) e++;
            if (m_lsu_acc) l++;
        end
        chk("stream_exu_done", 32'(e), 32'd8);
        chk("stream_lsu_done", 32'(l), 32'd8);
        idle();
        for (int c = 0; c < 10 && lsu_q.size() > 0; c++) cycle();
        cycle();

        // EXU always valid while loads pour in, to fill the FIFO
        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            exu_valid = 1'b1; exu_rd = AW'(17 + (c % 8)); exu_data = 32'hC000_0000 + 32'(c);
            lsu_valid = 1'b1; lsu_rd = AW'(20 + (n % 8)); lsu_data = 32'hB000_0000 + 32'(n);
            cycle();
            if (m_lsu_acc) n++;
        end
        chk("fill_loads_done", 32'(n), 32'd10);
        idle();
        for (int c = 0; c < 10 && lsu_q.size() > 0; c++) cycle();

        // rd=0 result is consumed but not written
        exu_valid = 1'b1; exu_rd = '0; exu_data = 32'h1234;
        cycle();
        idle();
        cycle();

        // Same-edge issue and completion of x7: bit stays set
        rs1 = 5'd7; rs2 = 5'd7;
        issue_valid = 1'b1; issue_rd = 5'd7;
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h0000_0777;
        cycle();
        idle();
        cycle();
        cycle();
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h0000_0778;
        cycle();
        idle();
        cycle();
        cycle();

        // Reset with loads buffered and registers pending
        issue_valid = 1'b1; issue_rd = 5'd10;
        cycle();
        issue_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && lsu_q.size() < 3; c++) begin
            exu_valid = 1'b1; exu_rd = 5'd2; exu_data = 32'h0000_0002 + 32'(c);
            lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h0000_0300 + 32'(c);
            cycle();
        end
        chk("pre_reset_fifo3", 32'(lsu_q.size()), 32'd3);
        idle();
        rs1 = 5'd10;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("post_reset_rs1", 32'(rs1_busy), 32'd0);
        cycle();

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            issue_rd    = AW'($urandom_range(0, 7));
            issue_valid = $urandom_range(0, 1) == 1 && !sb[issue_rd];
            exu_valid   = $urandom_range(0, 2) != 0;
            exu_rd      = AW'($urandom_range(0, 7));
            exu_data    = $urandom;
            lsu_valid   = $urandom_range(0, 1) == 1;
            lsu_rd      = AW'($urandom_range(0, 7));
            lsu_data    = $urandom;
            rs1         = AW'($urandom_range(0, 7));
            rs2         = AW'($urandom_range(0, 7));
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
